// File: rtl/mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | mem_arbiter: 2:1 inst/data memory arbiter with grant lock and in-order      |
// | response routing. Build option MEM_ARBITER_ROUND_ROBIN_EN selects           |
// | round-robin; default is fixed priority with data over inst.                 |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module mem_arbiter #(
  parameter int Xlen     = 64,
  parameter int MaskBits = Xlen / 8,
  parameter int Depth    = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inst_valid_i,
  input  logic                data_valid_i,
  output logic                inst_ready_o,
  output logic                data_ready_o,
  input  logic [Xlen-1:0]     inst_addr_i,
  input  logic [Xlen-1:0]     data_addr_i,
  input  logic [Xlen-1:0]     inst_wdata_i,
  input  logic [Xlen-1:0]     data_wdata_i,
  input  logic [MaskBits-1:0] inst_wmask_i,
  input  logic [MaskBits-1:0] data_wmask_i,
  output logic [Xlen-1:0]     inst_rdata_o,
  output logic [Xlen-1:0]     data_rdata_o,
  output logic                inst_rvalid_o,
  output logic                data_rvalid_o,
  output logic                mem_valid_o,
  input  logic                mem_ready_i,
  output logic [Xlen-1:0]     mem_addr_o,
  output logic [Xlen-1:0]     mem_wdata_o,
  output logic [MaskBits-1:0] mem_wmask_o,
  input  logic [Xlen-1:0]     mem_rdata_i,
  input  logic                mem_rvalid_i,
  output logic                err_o
);

  localparam int             PTR_W    = $clog2(Depth);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(Depth);

  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [Depth-1:0] owner_q, owner_d;
  logic             locked_q, locked_d;
  logic             locked_id_q, locked_id_d;
  logic             err_q, err_d;
  logic             grant;
  logic             accept;
  logic             pop;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
  logic             last_q, last_d;
`endif

  // Grant: 0 = inst, 1 = data.
  always_comb begin
    grant = data_valid_i;
    if (locked_q) begin
      grant = locked_id_q;
    end else if (inst_valid_i && data_valid_i) begin
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      grant = ~last_q;
`else
      grant = 1'b1;
`endif
    end
  end

  assign mem_valid_o   = (inst_valid_i || data_valid_i) && (count_q != CNT_FULL);
  assign accept        = mem_valid_o && mem_ready_i;
  assign inst_ready_o  = accept && !grant;
  assign data_ready_o  = accept && grant;
  assign mem_addr_o    = grant ? data_addr_i  : inst_addr_i;
  assign mem_wdata_o   = grant ? data_wdata_i : inst_wdata_i;
  assign mem_wmask_o   = grant ? data_wmask_i : inst_wmask_i;

  assign pop           = mem_rvalid_i && (count_q != '0);
  assign inst_rvalid_o = pop && !owner_q[head_q];
  assign data_rvalid_o = pop && owner_q[head_q];
  assign inst_rdata_o  = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;
  assign err_o         = err_q;

  always_comb begin
    owner_d     = owner_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    locked_d    = locked_q;
    locked_id_d = locked_id_q;
    err_d       = mem_rvalid_i && (count_q == '0);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    last_d      = last_q;
`endif
    if (accept) begin
      owner_d[tail_q] = grant;
      tail_d          = tail_q + PTR_W'(1);
      locked_d        = 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_d          = grant;
`endif
    end else if (mem_valid_o) begin
      // Stalled request: pin the grant until the downstream takes it.
      locked_d    = 1'b1;
      locked_id_d = grant;
    end
    if (pop) begin
      head_d = head_q + PTR_W'(1);
    end
    case ({accept, pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      locked_q    <= 1'b0;
      locked_id_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      // Last grant reads as data so inst wins the first contested round.
      last_q      <= 1'b1;
`endif
    end else begin
      owner_q     <= owner_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      locked_q    <= locked_d;
      locked_id_q <= locked_id_d;
      err_q       <= err_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
      last_q      <= last_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_mem_arbiter: directed self-checking bench for mem_arbiter.               |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_mem_arbiter;
  localparam int Xlen     = 64;
  localparam int MaskBits = 8;
  localparam int Depth    = 4;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b1;
  logic                inst_valid_i, data_valid_i;
  logic                inst_ready_o, data_ready_o;
  logic [Xlen-1:0]     inst_addr_i, data_addr_i, inst_wdata_i, data_wdata_i;
  logic [MaskBits-1:0] inst_wmask_i, data_wmask_i;
  logic [Xlen-1:0]     inst_rdata_o, data_rdata_o;
  logic                inst_rvalid_o, data_rvalid_o;
  logic                mem_valid_o, mem_ready_i;
  logic [Xlen-1:0]     mem_addr_o, mem_wdata_o;
  logic [MaskBits-1:0] mem_wmask_o;
  logic [Xlen-1:0]     mem_rdata_i;
  logic                mem_rvalid_i;
  logic                err_o;

  int total = 0;
  int bad   = 0;
  bit own_q[$];
  bit rr_last;

  mem_arbiter #(.Xlen(Xlen), .MaskBits(MaskBits), .Depth(Depth)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .inst_valid_i(inst_valid_i), .data_valid_i(data_valid_i),
    .inst_ready_o(inst_ready_o), .data_ready_o(data_ready_o),
    .inst_addr_i(inst_addr_i), .data_addr_i(data_addr_i),
    .inst_wdata_i(inst_wdata_i), .data_wdata_i(data_wdata_i),
    .inst_wmask_i(inst_wmask_i), .data_wmask_i(data_wmask_i),
    .inst_rdata_o(inst_rdata_o), .data_rdata_o(data_rdata_o),
    .inst_rvalid_o(inst_rvalid_o), .data_rvalid_o(data_rvalid_o),
    .mem_valid_o(mem_valid_o), .mem_ready_i(mem_ready_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_rdata_i(mem_rdata_i), .mem_rvalid_i(mem_rvalid_i),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    inst_valid_i = 1'b0; data_valid_i = 1'b0;
    inst_addr_i  = '0;   data_addr_i  = '0;
    inst_wdata_i = '0;   data_wdata_i = '0;
    inst_wmask_i = '0;   data_wmask_i = '0;
    mem_ready_i  = 1'b0; mem_rvalid_i = 1'b0;
    mem_rdata_i  = '0;
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b1;
    cyc();
    cyc();
    rst_i = 1'b0;
    own_q.delete();
    rr_last = 1'b1;
  endtask

  // Expected grant when both requesters are valid and unlocked.
  function automatic bit both_grant();
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    return ~rr_last;
`else
    return 1'b1;
`endif
  endfunction

  // Applied inside a cycle where mem_rvalid_i is already driven.
  task automatic check_resp(input string tag, input logic [63:0] rdata);
    bit own;
    own = (own_q.size() != 0) ? own_q.pop_front() : 1'b0;
    check({tag, "_inst_rv"}, inst_rvalid_o, !own);
    check({tag, "_data_rv"}, data_rvalid_o, own);
    check({tag, "_rdata"}, own ? data_rdata_o : inst_rdata_o, rdata);
  endtask

  initial begin
    bit g;
    do_reset();

    // Reset state with idle inputs
    cyc(); #1;
    check("rst_mem_valid", mem_valid_o, 0);
    check("rst_inst_ready", inst_ready_o, 0);
    check("rst_data_ready", data_ready_o, 0);
    check("rst_inst_rvalid", inst_rvalid_o, 0);
    check("rst_data_rvalid", data_rvalid_o, 0);
    check("rst_err", err_o, 0);

    // Single inst read, same-cycle accept, response two cycles later
    cyc();
    inst_valid_i = 1'b1; inst_addr_i = 64'h1000; mem_ready_i = 1'b1;
    #1;
    check("s_inst_ready", inst_ready_o, 1);
    check("s_data_ready", data_ready_o, 0);
    check("s_mem_valid", mem_valid_o, 1);
    check("s_mem_addr", mem_addr_o, 64'h1000);
    own_q.push_back(1'b0);
    cyc(); idle_inputs();
    cyc(); mem_rvalid_i = 1'b1; mem_rdata_i = 64'hDEAD;
    #1; check_resp("s", 64'hDEAD);
    cyc(); idle_inputs();

    // Both requesters valid, fill the FIFO
    do_reset();
    cyc();
    inst_valid_i = 1'b1; inst_addr_i = 64'h100;
    data_valid_i = 1'b1; data_addr_i = 64'h200;
    mem_ready_i  = 1'b1;
    for (int i = 0; i < Depth; i++) begin
      if (i != 0) cyc();
      #1;
      g = both_grant();
      check($sformatf("both%0d_data_ready", i), data_ready_o, g);
      check($sformatf("both%0d_inst_ready", i), inst_ready_o, !g);
      check($sformatf("both%0d_addr", i), mem_addr_o, g ? 64'h200 : 64'h100);
      own_q.push_back(g); rr_last = g;
    end
    cyc(); #1;
    check("full_mem_valid", mem_valid_o, 0);
    check("full_inst_ready", inst_ready_o, 0);
    check("full_data_ready", data_ready_o, 0);
    // Pop while full: no same-cycle refill
    cyc(); mem_rvalid_i = 1'b1; mem_rdata_i = 64'h5;
    #1;
    check("fullpop_mem_valid", mem_valid_o, 0);
    check_resp("fullpop", 64'h5);
    cyc(); mem_rvalid_i = 1'b0;
    #1;
    g = both_grant();
    check("refill_mem_valid", mem_valid_o, 1);
    check("refill_data_ready", data_ready_o, g);
    own_q.push_back(g); rr_last = g;
    cyc(); idle_inputs();
    for (int i = 0; i < Depth; i++) begin
      cyc(); mem_rvalid_i = 1'b1; mem_rdata_i = 64'(i + 16);
      #1; check_resp($sformatf("drain%0d", i), 64'(i + 16));
    end
    cyc(); idle_inputs();

    // Lock: inst stalled, data arrives later, grant stays on inst
    do_reset();
    cyc();
    inst_valid_i = 1'b1; inst_addr_i = 64'h2000;
    #1;
    check("lk0_mem_valid", mem_valid_o, 1);
    check("lk0_addr", mem_addr_o, 64'h2000);
    check("lk0_inst_ready", inst_ready_o, 0);
    cyc();
    data_valid_i = 1'b1; data_addr_i = 64'h3000;
    #1;
    check("lk1_addr", mem_addr_o, 64'h2000);
    check("lk1_data_ready", data_ready_o, 0);
    cyc(); #1;
    check("lk2_addr", mem_addr_o, 64'h2000);
    cyc(); mem_ready_i = 1'b1;
    #1;
    check("lk3_inst_ready", inst_ready_o, 1);
    check("lk3_data_ready", data_ready_o, 0);
    check("lk3_addr", mem_addr_o, 64'h2000);
    own_q.push_back(1'b0);
    cyc(); inst_valid_i = 1'b0;
    #1;
    check("lk4_data_ready", data_ready_o, 1);
    check("lk4_addr", mem_addr_o, 64'h3000);
    own_q.push_back(1'b1);
    cyc(); idle_inputs();
    cyc(); mem_rvalid_i = 1'b1; mem_rdata_i = 64'hA; #1; check_resp("lkr0", 64'hA);
    cyc(); mem_rvalid_i = 1'b1; mem_rdata_i = 64'hB; #1; check_resp("lkr1", 64'hB);
    cyc(); idle_inputs();

    // Interleaved inst/data(write)/inst, responses 1,2,3
    do_reset();
    cyc(); mem_ready_i = 1'b1; inst_valid_i = 1'b1; inst_addr_i = 64'h40;
    #1; check("il0_inst_ready", inst_ready_o, 1); own_q.push_back(1'b0);
    cyc(); inst_valid_i = 1'b0;
    data_valid_i = 1'b1; data_addr_i = 64'h80; data_wdata_i = 64'hCAFE; data_wmask_i = 8'h0F;
    #1;
    check("il1_data_ready", data_ready_o, 1);
    check("il1_wdata", mem_wdata_o, 64'hCAFE);
    check("il1_wmask", mem_wmask_o, 64'h0F);
    own_q.push_back(1'b1);
    cyc(); data_valid_i = 1'b0; data_wmask_i = '0; inst_valid_i = 1'b1; inst_addr_i = 64'h44;
    #1; check("il2_inst_ready", inst_ready_o, 1); own_q.push_back(1'b0);
    cyc(); idle_inputs();
    for (int i = 1; i <= 3; i++) begin
      cyc(); mem_rvalid_i = 1'b1; mem_rdata_i = 64'(i);
      #1; check_resp($sformatf("ilr%0d", i), 64'(i));
    end
    cyc(); idle_inputs();

    // Stray response with nothing outstanding
    do_reset();
    cyc(); mem_rvalid_i = 1'b1; mem_rdata_i = 64'h77;
    #1;
    check("stray_inst_rv", inst_rvalid_o, 0);
    check("stray_data_rv", data_rvalid_o, 0);
    check("stray_err_same", err_o, 0);
    cyc(); idle_inputs();
    #1; check("stray_err_pulse", err_o, 1);
    cyc(); #1; check("stray_err_clear", err_o, 0);

    // Reset mid-flight with two outstanding
    cyc(); mem_ready_i = 1'b1; inst_valid_i = 1'b1;
    cyc(); inst_valid_i = 1'b0; data_valid_i = 1'b1;
    cyc(); idle_inputs();
    #2 rst_i = 1'b1;
    #1;
    check("mid_rst_err", err_o, 0);
    check("mid_rst_mem_valid", mem_valid_o, 0);
    cyc(); rst_i = 1'b0; own_q.delete(); rr_last = 1'b1;
    cyc(); mem_rvalid_i = 1'b1;
    #1;
    check("post_rst_inst_rv", inst_rvalid_o, 0);
    check("post_rst_data_rv", data_rvalid_o, 0);
    cyc(); idle_inputs();
    #1; check("post_rst_err", err_o, 1);
    cyc(); #1; check("post_rst_err_clear", err_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
# mem_arbiter

Two-to-one memory arbiter that shares a single downstream memory port between the core's instruction-fetch requester (`inst`) and load/store requester (`data`). It sits between `core` and a unified memory/bus model. It grants one request per handshake and holds the grant stable until the request is accepted. It records the grant owner of every accepted request in an ordering FIFO so that in-order responses return to the correct requester.

## Interface
- `Xlen`, 64, address/data width.
- `MaskBits`, `Xlen/8`, write-mask width.
- `Depth`, 4, maximum outstanding accepted-but-unanswered requests; power of two, ≥2.
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `inst_valid_i`, `data_valid_i`  in  1  request valid per requester.
- `inst_ready_o`, `data_ready_o`  out  1  request accepted this cycle.
- `inst_addr_i`, `data_addr_i`  in  Xlen  request address.
- `inst_wdata_i`, `data_wdata_i`  in  Xlen  store data.
- `inst_wmask_i`, `data_wmask_i`  in  MaskBits  byte write mask; 0 = read.
- `inst_rdata_o`, `data_rdata_o`  out  Xlen  response data; both driven from `mem_rdata_i`.
- `inst_rvalid_o`, `data_rvalid_o`  out  1  response valid, routed by owner.
- `mem_valid_o`  out  1  downstream request valid.
- `mem_ready_i`  in  1  downstream accepts.
- `mem_addr_o`, `mem_wdata_o`, `mem_wmask_o`  out  Xlen/Xlen/MaskBits  muxed request fields.
- `mem_rdata_i`  in  Xlen  downstream response data.
- `mem_rvalid_i`  in  1  downstream response valid.
- `err_o`  out  1  one-cycle pulse: response arrived with no outstanding request.

## Operation
- Accept event: `mem_valid_o && mem_ready_i`. The granted requester's `*_ready_o` equals `mem_ready_i` gated by the grant. The other requester's ready is 0.
- Every accepted request, read or write, produces exactly one `mem_rvalid_i` pulse. Responses arrive in acceptance order, at least 1 cycle after acceptance.
- Grant selection happens only when unlocked. The candidates are the requesters with valid high. The policy is set by the Configuration macro.
- Lock: if `mem_valid_o` is high and `mem_ready_i` is low, set `locked`/`locked_id`. While locked, the grant is `locked_id` regardless of the other requester. The lock clears on accept. Requesters hold valid and fields stable until ready, per codebase handshake.
- `mem_valid_o` = (any valid) && (count < Depth). When the FIFO is full, no grant is issued, both readies are 0, and the lock is unchanged.
- Ordering FIFO holds the owner ID (1 bit: 0 = inst, 1 = data). It pushes on accept and pops on `mem_rvalid_i`. Pointers are log2(Depth) bits and wrap. The count is log2(Depth)+1 bits.
- Response routing: `inst_rvalid_o = mem_rvalid_i && count!=0 && head==0`. `data_rvalid_o` is the same with head==1.
- `mem_rvalid_i` with count==0: no pop, no rvalid, `err_o` pulses the next cycle (registered).
- Simultaneous push and pop: count is unchanged and both pointers advance. When full, the pop still happens but the push is blocked by `mem_valid_o`=0 that cycle (no same-cycle refill).
- Reset, asserted at any time: pointers, count, lock, RR state and `err_o` clear. Outstanding responses are discarded; later stray `mem_rvalid_i` flags `err_o`.

## Timing
- Request path is combinational valid→mem, with 0 cycles added latency. A request on an idle, non-full arbiter with `mem_ready_i`=1 is accepted in the same cycle.
- Response path is combinational `mem_rvalid_i`→`*_rvalid_o`, with 0 cycles added.
- Reset values: `err_o`=0, count=0, unlocked. All outputs are then combinational from idle state, so readies and rvalids are 0 and `mem_valid_o` is 0 while inputs are idle.
- RR pointer and lock update on the rising edge following the accept.

## Configuration
- `MEM_ARBITER_ROUND_ROBIN_EN` defined: round-robin arbitration. When both request, the grant goes to the requester not granted at the last accept. After reset `inst` has priority.
- Not defined: fixed priority, `data` over `inst` (the load/store unit stalls the pipeline longer). `inst` can starve under continuous data requests.

## Test plan
- Single inst read at addr 0x1000, `mem_ready_i`=1, response 2 cycles later with rdata 0xDEAD → `inst_ready_o`=1 in the accept cycle, and 2 cycles later `inst_rvalid_o`=1 with `inst_rdata_o`=0xDEAD and `data_rvalid_o`=0.
- Both requesters valid every cycle, `mem_ready_i`=1 → with the RR macro defined, grants alternate inst,data,inst,data. With the macro undefined, all 4 grants go to data.
- inst valid, `mem_ready_i`=0 for 3 cycles, data asserts in cycle 2 → `mem_addr_o` stays the inst address until accept, and data is granted only afterward.
- Depth=4: 4 accepts with no responses → `mem_valid_o`=0 and both readies 0. One `mem_rvalid_i` → the next cycle accepts one more.
- Interleaved inst/data/inst accepts, then 3 responses with rdata 1,2,3 → rvalid routed inst(1), data(2), inst(3).
- `mem_rvalid_i` pulse with nothing outstanding, and reset asserted mid-flight with 2 outstanding → no rvalid outputs, `err_o` pulses 1 cycle, count is 0 after reset.
